// File: rtl/ahb_enum_types_pkg.sv
// Shared AHB-Lite encodings for HTRANS, HSIZE, HBURST and HRESP.
package ahb_enum_types_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_htrans_enum;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4W    = 3'b100,
    HSIZE_8W    = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } ahb_hsize_enum;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } ahb_hburst_enum;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } ahb_hresp_enum;

endpackage

// File: rtl/pcounter_regs_pkg.sv
// Register map, CTRL/STATUS bit positions and response FSM states for the pcounter slave.
package pcounter_regs_pkg;

  localparam logic [3:0] CTRL_OFS   = 4'h0;
  localparam logic [3:0] LIMIT_OFS  = 4'h4;
  localparam logic [3:0] COUNT_OFS  = 4'h8;
  localparam logic [3:0] STATUS_OFS = 4'hC;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_DIR_BIT    = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int STATUS_WRAP_BIT = 0;

  typedef enum logic [1:0] {
    IDLE_OK = 2'd0,
    ERR1    = 2'd1,
    ERR2    = 2'd2
  } resp_state_e;

  // Word-aligned register index as seen on HADDR[3:2].
  function automatic logic [1:0] reg_sel(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage

// File: rtl/pcounter_core.sv
// Programmable up/down counter with wrap status and optional registered irq
// (irq output and CTRL.IRQ_EN exist only when PCOUNT_IRQ_EN is defined).
module pcounter_core
  import pcounter_regs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_we,
  input  logic              limit_we,
  input  logic              count_we,
  input  logic              status_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [2:0]        ctrl,
  output logic [CNT_W-1:0]  limit,
  output logic [CNT_W-1:0]  count,
  output logic              wrap,
  output logic              cnt_wrap
`ifdef PCOUNT_IRQ_EN
  , output logic            irq
`endif
);

  logic             en_q;
  logic             dir_q;
  logic             irq_en;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             wrap_q;
  logic             cnt_wrap_q;
  logic             wrap_evt;
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

  // A COUNT load wins over counting; an up-count past a limit below COUNT rolls over at all-ones.
  always_comb begin
    count_nxt = count_q;
    wrap_evt  = 1'b0;
    if (count_we) begin
      count_nxt = wdata[CNT_W-1:0];
    end else if (en_q) begin
      if (!dir_q) begin
        if (count_q == limit_q) begin
          count_nxt = '0;
          wrap_evt  = 1'b1;
        end else begin
          count_nxt = count_q + CNT_W'(1);
          wrap_evt  = (count_q == '1);
        end
      end else begin
        if (count_q == '0) begin
          count_nxt = limit_q;
          wrap_evt  = 1'b1;
        end else begin
          count_nxt = count_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      dir_q      <= 1'b0;
      limit_q    <= '1;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      cnt_wrap_q <= 1'b0;
    end else begin
      if (ctrl_we) begin
        en_q  <= wdata[CTRL_EN_BIT];
        dir_q <= wdata[CTRL_DIR_BIT];
      end
      if (limit_we) begin
        limit_q <= wdata[CNT_W-1:0];
      end
      count_q    <= count_nxt;
      cnt_wrap_q <= wrap_evt;
      // A fresh wrap outranks a simultaneous write-1-to-clear.
      if (wrap_evt) begin
        wrap_q <= 1'b1;
      end else if (status_we && wdata[STATUS_WRAP_BIT]) begin
        wrap_q <= 1'b0;
      end
    end
  end

`ifdef PCOUNT_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_we) begin
        irq_en_q <= wdata[CTRL_IRQ_EN_BIT];
      end
      irq_q <= wrap_q & irq_en_q;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  assign ctrl     = {irq_en, dir_q, en_q};
  assign limit    = limit_q;
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign cnt_wrap = cnt_wrap_q;

endmodule

// File: rtl/ahb_pcounter_slave.sv
// AHB-Lite slave exposing the pcounter registers (CTRL, LIMIT, COUNT, STATUS).
// Define PCOUNT_IRQ_EN to add the irq output and CTRL.IRQ_EN.
//
// state   | meaning
// IDLE_OK | zero-wait OKAY; legal transfers complete here
// ERR1    | first ERROR cycle, HREADYOUT low
// ERR2    | second ERROR cycle, HREADYOUT high; a new transfer may be accepted
module ahb_pcounter_slave
  import ahb_enum_types_pkg::*;
  import pcounter_regs_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic              cnt_wrap
`ifdef PCOUNT_IRQ_EN
  , output logic            irq
`endif
);

  logic           accept;
  logic           illegal;
  logic           dp_valid;
  logic           dp_write;
  logic           dp_legal;
  logic [1:0]     dp_sel;
  resp_state_e    state_q;
  logic           hreadyout_q;
  ahb_hresp_enum  hresp_q;
  logic           wr_commit;
  logic           rd_en;
  logic           ctrl_we;
  logic           limit_we;
  logic           count_we;
  logic           status_we;
  logic [2:0]       ctrl;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] count;
  logic             wrap;
  logic             unused_hburst;

  assign unused_hburst = ^HBURST;

  assign accept  = HSEL && HREADY &&
                   ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign illegal = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00) ||
                   (HADDR[ADDR_W-1:4] != '0);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_legal <= 1'b0;
      dp_sel   <= 2'b00;
    end else if (HREADY) begin
      dp_valid <= accept;
      dp_write <= HWRITE;
      dp_legal <= !illegal;
      dp_sel   <= HADDR[3:2];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE_OK;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state_q)
        IDLE_OK, ERR2: begin
          if (accept && illegal) begin
            state_q     <= ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else begin
            state_q     <= IDLE_OK;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        ERR1: begin
          state_q     <= ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= IDLE_OK;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  // Legal transfers never wait, so a write commits on the edge closing its data phase.
  assign wr_commit = dp_valid && dp_write && dp_legal && hreadyout_q;
  assign rd_en     = dp_valid && !dp_write && dp_legal;
  assign ctrl_we   = wr_commit && (dp_sel == reg_sel(CTRL_OFS));
  assign limit_we  = wr_commit && (dp_sel == reg_sel(LIMIT_OFS));
  assign count_we  = wr_commit && (dp_sel == reg_sel(COUNT_OFS));
  assign status_we = wr_commit && (dp_sel == reg_sel(STATUS_OFS));

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (dp_sel)
        reg_sel(CTRL_OFS):   HRDATA = DATA_W'(ctrl);
        reg_sel(LIMIT_OFS):  HRDATA = DATA_W'(limit);
        reg_sel(COUNT_OFS):  HRDATA = DATA_W'(count);
        reg_sel(STATUS_OFS): HRDATA = DATA_W'(wrap);
        default:             HRDATA = '0;
      endcase
    end
  end

  pcounter_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_core (
    .clk       (HCLK),
    .rst       (HRESET),
    .ctrl_we   (ctrl_we),
    .limit_we  (limit_we),
    .count_we  (count_we),
    .status_we (status_we),
    .wdata     (HWDATA),
    .ctrl      (ctrl),
    .limit     (limit),
    .count     (count),
    .wrap      (wrap),
    .cnt_wrap  (cnt_wrap)
`ifdef PCOUNT_IRQ_EN
    , .irq     (irq)
`endif
  );

endmodule

// File: tb/tb_ahb_pcounter_slave.sv
// Directed self-checking bench for ahb_pcounter_slave; irq steps run when PCOUNT_IRQ_EN is defined.
module tb_ahb_pcounter_slave;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  wire         HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic        cnt_wrap;
`ifdef PCOUNT_IRQ_EN
  logic        irq;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] rd;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_pcounter_slave dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .cnt_wrap  (cnt_wrap)
`ifdef PCOUNT_IRQ_EN
    , .irq     (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    HBURST = 3'b000;
  endtask

  task automatic addr_phase(input logic [11:0] a, input logic w, input logic [2:0] sz);
    HSEL   = 1'b1;
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = w;
    HSIZE  = sz;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1, 3'b010);
    tick();
    idle_bus();
    HWDATA = d;
    tick();
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0, 3'b010);
    tick();
    idle_bus();
    d = HRDATA;
    tick();
  endtask

  initial begin
    logic [11:0] bad_addr [2];
    bad_addr[0] = 12'h104;
    bad_addr[1] = 12'h006;

    idle_bus();
    HADDR  = '0;
    HWDATA = '0;
    HRESET = 1'b1;
    tick();
    tick();
    check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    check("rst_hresp", 32'(HRESP), 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_cnt_wrap", 32'(cnt_wrap), 32'h0);
    HRESET = 1'b0;
    bus_read(12'h0, rd);  check("rst_ctrl", rd, 32'h0);
    bus_read(12'h4, rd);  check("rst_limit", rd, 32'h0000_FFFF);
    bus_read(12'h8, rd);  check("rst_count", rd, 32'h0);
    bus_read(12'hC, rd);  check("rst_status", rd, 32'h0);

    // byte-sized write to LIMIT: two-cycle ERROR, no commit
    addr_phase(12'h4, 1'b1, 3'b000);
    tick();
    idle_bus();
    HWDATA = 32'h1234;
    check("err1_hreadyout", 32'(HREADYOUT), 32'h0);
    check("err1_hresp", 32'(HRESP), 32'h1);
    tick();
    check("err2_hreadyout", 32'(HREADYOUT), 32'h1);
    check("err2_hresp", 32'(HRESP), 32'h1);
    tick();
    check("err_done_hresp", 32'(HRESP), 32'h0);
    bus_read(12'h4, rd);  check("err_limit_kept", rd, 32'h0000_FFFF);

    // out-of-window and misaligned reads both error and return zero
    for (int i = 0; i < 2; i++) begin
      addr_phase(bad_addr[i], 1'b0, 3'b010);
      tick();
      idle_bus();
      check("bad_rd_hrdata", HRDATA, 32'h0);
      check("bad_rd_hresp", 32'(HRESP), 32'h1);
      tick();
      tick();
    end

    // up-count with LIMIT=3
    bus_write(12'h4, 32'h3);
    bus_write(12'h0, 32'h1);
    check("up_c0", 32'(dut.u_core.count_q), 32'h0);
    tick(); check("up_c1", 32'(dut.u_core.count_q), 32'h1); check("up_cw1", 32'(cnt_wrap), 32'h0);
    tick(); check("up_c2", 32'(dut.u_core.count_q), 32'h2);
    tick(); check("up_c3", 32'(dut.u_core.count_q), 32'h3);
    tick(); check("up_c4", 32'(dut.u_core.count_q), 32'h0); check("up_cw4", 32'(cnt_wrap), 32'h1);
    tick(); check("up_c5", 32'(dut.u_core.count_q), 32'h1); check("up_cw5", 32'(cnt_wrap), 32'h0);
    bus_read(12'hC, rd);  check("up_status", rd, 32'h1);

    // down-count reload from 0 to LIMIT=5
    bus_write(12'h0, 32'h0);
    check("stop_count", 32'(dut.u_core.count_q), 32'h1);
    bus_write(12'h4, 32'h5);
    bus_write(12'h8, 32'h0);
    bus_write(12'h0, 32'h3);
    check("dn_c0", 32'(dut.u_core.count_q), 32'h0);
    tick();
    check("dn_reload", 32'(dut.u_core.count_q), 32'h5);
    check("dn_cw", 32'(cnt_wrap), 32'h1);
    bus_write(12'h0, 32'h0);
    check("dn_stop", 32'(dut.u_core.count_q), 32'h3);
    bus_read(12'hC, rd);  check("dn_status_set", rd, 32'h1);
    bus_write(12'hC, 32'h1);
    bus_read(12'hC, rd);  check("w1c_clear", rd, 32'h0);

    // LIMIT=0 up: holds at 0 and wraps every cycle; wrap beats W1C
    bus_write(12'h4, 32'h0);
    bus_write(12'h8, 32'h0);
    bus_write(12'h0, 32'h1);
    tick();
    check("lim0_count", 32'(dut.u_core.count_q), 32'h0);
    check("lim0_cw", 32'(cnt_wrap), 32'h1);
    bus_write(12'hC, 32'h1);
    check("wrap_beats_clear", 32'(dut.u_core.wrap_q), 32'h1);

    // COUNT load beats counting; above-limit count rolls over at all-ones
    bus_write(12'h8, 32'h7);
    check("load_count", 32'(dut.u_core.count_q), 32'h7);
    check("load_no_wrap", 32'(cnt_wrap), 32'h0);
    tick();
    check("above_lim_inc", 32'(dut.u_core.count_q), 32'h8);
    check("above_lim_cw", 32'(cnt_wrap), 32'h0);
    bus_write(12'h8, 32'hFFFE);
    tick();
    check("ones_count", 32'(dut.u_core.count_q), 32'hFFFF);
    check("ones_cw", 32'(cnt_wrap), 32'h0);
    tick();
    check("ones_roll", 32'(dut.u_core.count_q), 32'h0);
    check("ones_roll_cw", 32'(cnt_wrap), 32'h1);
    bus_write(12'h0, 32'h0);

    // back-to-back write then read of COUNT
    addr_phase(12'h8, 1'b1, 3'b010);
    tick();
    addr_phase(12'h8, 1'b0, 3'b010);
    HWDATA = 32'h1234;
    check("b2b_wr_ready", 32'(HREADYOUT), 32'h1);
    tick();
    idle_bus();
    check("b2b_rd_ready", 32'(HREADYOUT), 32'h1);
    check("b2b_rd_data", HRDATA, 32'h1234);
    tick();

    // INCR4 write interleaved with BUSY and IDLE
    addr_phase(12'h8, 1'b1, 3'b010);
    HBURST = 3'b011;
    tick();
    HTRANS = 2'b01;
    HADDR  = 12'hC;
    HWDATA = 32'h55;
    check("busy1_ready", 32'(HREADYOUT), 32'h1);
    check("busy1_resp", 32'(HRESP), 32'h0);
    tick();
    HWDATA = 32'hFFFF_FFFF;
    check("busy2_ready", 32'(HREADYOUT), 32'h1);
    check("busy2_resp", 32'(HRESP), 32'h0);
    tick();
    HTRANS = 2'b00;
    HADDR  = 12'h4;
    check("idle_ready", 32'(HREADYOUT), 32'h1);
    tick();
    idle_bus();
    check("idle_resp", 32'(HRESP), 32'h0);
    tick();
    bus_read(12'h8, rd);  check("burst_count", rd, 32'h55);
    bus_read(12'hC, rd);  check("busy_status_kept", rd, 32'h1);
    bus_read(12'h4, rd);  check("idle_limit_kept", rd, 32'h0);

    // reset during a write data phase
    bus_write(12'h0, 32'h2);
    addr_phase(12'h4, 1'b1, 3'b010);
    tick();
    idle_bus();
    HWDATA = 32'h22;
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    bus_read(12'h0, rd);  check("mid_rst_ctrl", rd, 32'h0);
    bus_read(12'h4, rd);  check("mid_rst_limit", rd, 32'h0000_FFFF);
    bus_read(12'h8, rd);  check("mid_rst_count", rd, 32'h0);
    bus_read(12'hC, rd);  check("mid_rst_status", rd, 32'h0);

`ifdef PCOUNT_IRQ_EN
    bus_write(12'h4, 32'h1);
    bus_write(12'h0, 32'h5);
    check("irq_idle", 32'(irq), 32'h0);
    tick();
    tick();
    check("irq_wrap_cw", 32'(cnt_wrap), 32'h1);
    check("irq_not_yet", 32'(irq), 32'h0);
    tick();
    check("irq_set", 32'(irq), 32'h1);
    bus_write(12'h0, 32'h4);
    check("irq_held", 32'(irq), 32'h1);
    bus_write(12'hC, 32'h1);
    check("irq_lag", 32'(irq), 32'h1);
    tick();
    check("irq_cleared", 32'(irq), 32'h0);
`else
    bus_write(12'h0, 32'h7);
    bus_read(12'h0, rd);  check("ctrl_bit2_ro", rd, 32'h3);
    bus_write(12'h0, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_pcounter_slave.md
Name: ahb_pcounter_slave

Overview:
AHB-Lite slave front end for the pcounter DUT. It sits directly downstream of the bus master and decodes HTRANS/HSIZE/HBURST using the shared AHB enum package. It exposes a four-register programmable counter (control, limit, count, status) and generates HREADYOUT/HRESP, including the two-cycle ERROR response.

Parameters:
ADDR_W, 12, HADDR bits decoded; the register window is HADDR[3:2] and the upper bits must be zero.
DATA_W, 32, HWDATA/HRDATA/counter width; only 32 is supported.
CNT_W, 16, width of the counter and limit registers; upper bits read as zero.

Ports:
HCLK  in  1  clock; all logic is on the rising edge
HRESET  in  1  synchronous, active-high reset
HSEL  in  1  slave select
HADDR  in  ADDR_W  address
HTRANS  in  2  ahb_htrans_enum
HWRITE  in  1  1 = write
HSIZE  in  3  ahb_hsize_enum
HBURST  in  3  ahb_hburst_enum; accepted but not used for decode
HWDATA  in  DATA_W  write data, valid in the data phase
HREADY  in  1  bus-level ready
HRDATA  out  DATA_W  read data
HREADYOUT  out  1  slave ready
HRESP  out  2  ahb_hresp_enum; only OKAY and ERROR are driven
cnt_wrap  out  1  one-cycle pulse on each counter wrap/reload

Behaviour:
- Reset (HRESET=1 at an edge): CTRL=0, LIMIT=0xFFFF, COUNT=0, STATUS=0, HREADYOUT=1, HRESP=OKAY, HRDATA=0, cnt_wrap=0, response FSM=IDLE_OK.
- Reset asserted mid-transfer aborts the transfer. No register write from that transfer commits.
- Address phase is accepted when HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ). On acceptance, register the address, HWRITE and a valid flag.
- IDLE or BUSY transfers (or HSEL=0) get a zero-wait OKAY and cause no side effects.
- An access is illegal if HSIZE != WORD, HADDR[1:0] != 0, or the upper address bits are non-zero.
- Response FSM states and transitions:
  - IDLE_OK: a legal accepted transfer stays here (zero wait, OKAY). An illegal one goes to ERR1.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Next state is ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Next state is IDLE_OK, unless a new transfer accepted here is illegal, in which case go to ERR1.
- Illegal accesses never modify registers and return HRDATA=0.
- Writes commit at the end of the data phase (HREADYOUT=1) from HWDATA.
- HRDATA is a combinational mux of the data-phase address over the current register values. A read immediately after a write to the same register therefore returns the new value.
- Register map:
  - 0x0 CTRL, RW: [0]=EN, [1]=DIR (0 = up, 1 = down).
  - 0x4 LIMIT, RW: [CNT_W-1:0].
  - 0x8 COUNT, RW: a write loads the counter.
  - 0xC STATUS: [0]=WRAP, write-1-to-clear.
- Counter updates once per cycle when EN=1:
  - Up mode: if COUNT==LIMIT then COUNT<=0, else COUNT+1.
  - Down mode: if COUNT==0 then COUNT<=LIMIT, else COUNT-1.
- A wrap or reload sets STATUS.WRAP and pulses cnt_wrap for one cycle.
- LIMIT=0 in up mode: COUNT holds at 0 and wraps every cycle.
- Priority rules:
  - A bus write to COUNT beats the counter update in the same cycle; no wrap is flagged that cycle.
  - A wrap set beats a W1C clear in the same cycle, so WRAP stays 1.
  - A write to CTRL takes effect on the next cycle's count.
  - COUNT above LIMIT in up mode counts up to all-ones, wraps to 0, and sets WRAP.

Optional Feature:
- Macro: PCOUNT_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and IRQ_EN at CTRL[2] (reset 0).
  - irq is registered: irq = STATUS.WRAP & IRQ_EN, one cycle after WRAP sets.
- Undefined: no irq port, and CTRL[2] reads 0 and ignores writes.

Decomposition:
- ahb_enum_types_pkg supplies the htrans, hresp and hsize enums, used unchanged.
- New package pcounter_regs_pkg holds:
  - register offset localparams (CTRL_OFS, LIMIT_OFS, COUNT_OFS, STATUS_OFS);
  - CTRL bit-index constants;
  - the response FSM state enum (IDLE_OK, ERR1, ERR2).
- Sub-module pcounter_core holds the counter, WRAP logic and the irq option. The slave keeps the AHB decode and FSM and drives the core through the write strobes and the COUNT load.

Test Plan:
- Write LIMIT=3, then CTRL=1 (EN, up) -> COUNT sequence 0,1,2,3,0; cnt_wrap pulses on the 3->0 edge; a read of STATUS returns 1.
- Write CTRL=3 (EN, down) with LIMIT=5 and COUNT=0 -> next cycle COUNT=5 and WRAP set. Write STATUS=1 -> reads 0 unless a wrap occurs in the same cycle.
- HSIZE=BYTE write to 0x4 -> HREADYOUT 0 then 1 with HRESP=ERROR on both cycles; LIMIT unchanged (0xFFFF).
- Back-to-back NONSEQ write 0x8=0x1234 then read 0x8 with EN=0 -> zero wait states; HRDATA=0x1234.
- BUSY and IDLE transfers interleaved with a burst (HBURST=INCR4) -> OKAY with zero wait and no register changes. Assert HRESET during a write data phase -> all registers return to their reset values.
- With PCOUNT_IRQ_EN defined and CTRL=5, LIMIT=1 -> irq asserts one cycle after the first wrap and drops after STATUS W1C.
